// File: rtl/pulse_train_gen_pkg.sv
`default_nettype none
// ============================================================================
//  pulse_train_gen_pkg
//  Shared state encoding for the pulse-train generator.
//  Revision: 1.0
// ============================================================================
package pulse_train_gen_pkg;

    localparam int CNT_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/pulse_train_gen_if.sv
`default_nettype none
// ============================================================================
//  pulse_train_gen_if
//  Command/config inputs and waveform/status outputs of the pulse-train generator.
//  Revision: 1.0
// ============================================================================
interface pulse_train_gen_if #(
    parameter int CNT_W = 8
) ();
    logic             start;
    logic             stop;
    logic [CNT_W-1:0] high_cycles;
    logic [CNT_W-1:0] low_cycles;
    logic [CNT_W-1:0] pulse_count;
    logic             out;
    logic             busy;
    logic             done;

    modport master (
        output start, stop, high_cycles, low_cycles, pulse_count,
        input  out, busy, done
    );

    modport slave (
        input  start, stop, high_cycles, low_cycles, pulse_count,
        output out, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/pulse_train_gen_phase_counter.sv
`default_nettype none
// ============================================================================
//  pulse_train_gen_phase_counter
//  Loadable down-counter with zero flag; saturates at zero instead of wrapping.
//  Revision: 1.0
// ============================================================================
module pulse_train_gen_phase_counter #(
    parameter int W = 8
) (
    input  wire logic         clk,
    input  wire logic         nrst,
    input  wire logic         load_i,
    input  wire logic [W-1:0] val_i,
    input  wire logic         dec_i,
    output logic      [W-1:0] cnt_o,
    output logic              zero_o
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);
endmodule
`default_nettype wire

// File: rtl/pulse_train_gen.sv
`default_nettype none
// ============================================================================
//  pulse_train_gen
//  Programmable train of N pulses, H cycles high / L cycles low, on a start command.
//  Revision: 1.0
// ============================================================================
module pulse_train_gen
    import pulse_train_gen_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  wire logic         clk,
    input  wire logic         nrst,
    pulse_train_gen_if.slave  bus
);
    state_e           state_q, state_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] high_q, low_q;
    logic             cfg_load;

    logic             ph_load, ph_dec, ph_zero;
    logic [CNT_W-1:0] ph_val;
    logic [CNT_W-1:0] ph_cnt_unused;

    logic             rem_load, rem_dec, rem_zero;
    logic [CNT_W-1:0] rem_val, rem_cnt;
    logic             rem_last;

    // A zero phase length behaves as one cycle, so the loaded count is max(v,1)-1.
    function automatic logic [CNT_W-1:0] eff_m1(input logic [CNT_W-1:0] v);
        return (v == '0) ? '0 : v - CNT_W'(1);
    endfunction

    assign rem_last = rem_zero || (rem_cnt == CNT_W'(1));

    always_comb begin
        state_d  = state_q;
        done_d   = 1'b0;
        cfg_load = 1'b0;
        ph_load  = 1'b0;
        ph_val   = '0;
        ph_dec   = 1'b0;
        rem_load = 1'b0;
        rem_val  = '0;
        rem_dec  = 1'b0;

        if (bus.stop) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        cfg_load = 1'b1;
                        if (bus.pulse_count != '0) begin
                            state_d  = ST_HIGH;
                            ph_load  = 1'b1;
                            ph_val   = eff_m1(bus.high_cycles);
                            rem_load = 1'b1;
                            rem_val  = bus.pulse_count;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                ST_HIGH: begin
                    if (!ph_zero) begin
                        ph_dec = 1'b1;
                    end else begin
                        state_d = ST_LOW;
                        ph_load = 1'b1;
                        ph_val  = eff_m1(low_q);
                    end
                end
                ST_LOW: begin
                    if (!ph_zero) begin
                        ph_dec = 1'b1;
                    end else if (rem_last) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_HIGH;
                        rem_dec = 1'b1;
                        ph_load = 1'b1;
                        ph_val  = eff_m1(high_q);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
            high_q  <= '0;
            low_q   <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            if (cfg_load) begin
                high_q <= bus.high_cycles;
                low_q  <= bus.low_cycles;
            end
        end
    end

    pulse_train_gen_phase_counter #(.W(CNT_W)) u_phase (
        .clk    (clk),
        .nrst   (nrst),
        .load_i (ph_load),
        .val_i  (ph_val),
        .dec_i  (ph_dec),
        .cnt_o  (ph_cnt_unused),
        .zero_o (ph_zero)
    );

    pulse_train_gen_phase_counter #(.W(CNT_W)) u_rem (
        .clk    (clk),
        .nrst   (nrst),
        .load_i (rem_load),
        .val_i  (rem_val),
        .dec_i  (rem_dec),
        .cnt_o  (rem_cnt),
        .zero_o (rem_zero)
    );

    assign bus.out  = (state_q == ST_HIGH);
    assign bus.busy = (state_q != ST_IDLE);
    assign bus.done = done_q;
endmodule
`default_nettype wire

// File: tb/tb_pulse_train_gen.sv
`default_nettype none
// ============================================================================
//  tb_pulse_train_gen
//  Directed self-checking bench for pulse_train_gen.
//  Revision: 1.0
// ============================================================================
module tb_pulse_train_gen;
    logic clk;
    logic nrst;
    int   n_checks;
    int   n_fail;

    pulse_train_gen_if #(.CNT_W(8)) bus ();

    pulse_train_gen #(.CNT_W(8)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Start a train at cycle 0 and check out/busy/done for cycles 1..ncyc+2.
    // pat[k-1] holds the hand-computed out value of cycle k.
    task automatic run_train(input string tag, input logic [7:0] h, input logic [7:0] l,
                             input logic [7:0] n, input int ncyc, input logic [63:0] pat);
        int   rises;
        int   falls;
        logic prev;
        bus.high_cycles = h;
        bus.low_cycles  = l;
        bus.pulse_count = n;
        bus.start       = 1'b1;
        next_cycle();
        bus.start       = 1'b0;
        bus.high_cycles = 8'd7;
        bus.low_cycles  = 8'd9;
        bus.pulse_count = 8'd1;
        rises = 0;
        falls = 0;
        prev  = 1'b0;
        for (int k = 1; k <= ncyc; k++) begin
            check_eq({tag, " out"}, bus.out, pat[k-1]);
            check_eq({tag, " busy"}, bus.busy, 1);
            check_eq({tag, " done early"}, bus.done, 0);
            if (bus.out && !prev) rises++;
            if (!bus.out && prev) falls++;
            prev = bus.out;
            next_cycle();
        end
        if (prev && !bus.out) falls++;
        check_eq({tag, " done"}, bus.done, 1);
        check_eq({tag, " busy end"}, bus.busy, 0);
        check_eq({tag, " out end"}, bus.out, 0);
        check_eq({tag, " rises"}, rises, n);
        check_eq({tag, " falls"}, falls, n);
        next_cycle();
        check_eq({tag, " done 1cyc"}, bus.done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic quiet;
        n_checks        = 0;
        n_fail          = 0;
        nrst            = 1'b0;
        bus.start       = 1'b0;
        bus.stop        = 1'b0;
        bus.high_cycles = '0;
        bus.low_cycles  = '0;
        bus.pulse_count = '0;
        repeat (3) next_cycle();
        check_eq("rst out", bus.out, 0);
        check_eq("rst busy", bus.busy, 0);
        check_eq("rst done", bus.done, 0);
        nrst = 1'b1;
        repeat (2) next_cycle();

        run_train("basic", 8'd2, 8'd3, 8'd2, 10, 64'h063);
        run_train("zero_hl", 8'd0, 8'd0, 8'd3, 6, 64'h015);

        // N=0: no pulse, done one cycle later
        bus.high_cycles = 8'd3;
        bus.low_cycles  = 8'd3;
        bus.pulse_count = 8'd0;
        bus.start       = 1'b1;
        next_cycle();
        bus.start = 1'b0;
        check_eq("n0 out", bus.out, 0);
        check_eq("n0 busy", bus.busy, 0);
        check_eq("n0 done", bus.done, 1);
        next_cycle();
        check_eq("n0 done 1cyc", bus.done, 0);
        check_eq("n0 out2", bus.out, 0);

        // Abort: stop sampled at end of cycle 6
        bus.high_cycles = 8'd4;
        bus.low_cycles  = 8'd4;
        bus.pulse_count = 8'd5;
        bus.start       = 1'b1;
        next_cycle();
        bus.start = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            check_eq("abort out", bus.out, (k <= 4) ? 1 : 0);
            check_eq("abort busy", bus.busy, 1);
            if (k == 6) bus.stop = 1'b1;
            next_cycle();
        end
        bus.stop = 1'b0;
        check_eq("abort out7", bus.out, 0);
        check_eq("abort busy7", bus.busy, 0);
        quiet = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (bus.done || bus.busy || bus.out) quiet = 1'b0;
            next_cycle();
        end
        check_eq("abort quiet", quiet, 1);

        // stop outranks start in IDLE
        bus.pulse_count = 8'd2;
        bus.start       = 1'b1;
        bus.stop        = 1'b1;
        next_cycle();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        check_eq("stopstart busy", bus.busy, 0);
        check_eq("stopstart done", bus.done, 0);
        next_cycle();

        // Retrigger: start held, H=L=N=1 -> period 3 (out 1,0,0; done on 3rd)
        bus.high_cycles = 8'd1;
        bus.low_cycles  = 8'd1;
        bus.pulse_count = 8'd1;
        bus.start       = 1'b1;
        next_cycle();
        for (int k = 0; k < 9; k++) begin
            check_eq("retrig out", bus.out, (k % 3 == 0) ? 1 : 0);
            check_eq("retrig busy", bus.busy, (k % 3 == 2) ? 0 : 1);
            check_eq("retrig done", bus.done, (k % 3 == 2) ? 1 : 0);
            if (k == 0) begin
                bus.high_cycles = 8'd5;
                bus.pulse_count = 8'd4;
            end else if (k == 1) begin
                bus.high_cycles = 8'd1;
                bus.pulse_count = 8'd1;
            end
            next_cycle();
        end
        bus.start = 1'b0;
        repeat (4) next_cycle();

        // Async reset mid-HIGH, off the clock edge
        bus.high_cycles = 8'd6;
        bus.low_cycles  = 8'd2;
        bus.pulse_count = 8'd3;
        bus.start       = 1'b1;
        next_cycle();
        bus.start = 1'b0;
        next_cycle();
        check_eq("arst pre out", bus.out, 1);
        #2;
        nrst = 1'b0;
        #1;
        check_eq("arst out", bus.out, 0);
        check_eq("arst busy", bus.busy, 0);
        check_eq("arst done", bus.done, 0);
        next_cycle();
        nrst = 1'b1;
        next_cycle();
        check_eq("arst idle done", bus.done, 0);
        run_train("post_rst", 8'd1, 8'd2, 8'd2, 6, 64'h009);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
